// File: rtl/phy_regfile_wb_arbiter_pkg.sv
// Shared configuration and types for the register-file write-back arbiter.
// Execution units can reuse wb_req_t to bundle a result with its destination.
package phy_regfile_wb_arbiter_pkg;

    localparam int DEF_REQ_NUM          = 4;
    localparam int DEF_WB_WIDTH         = 2;
    localparam int DEF_PHY_REG_ID_WIDTH = 7;
    localparam int DEF_REG_DATA_WIDTH   = 32;

    typedef struct packed {
        logic [DEF_PHY_REG_ID_WIDTH-1:0] id;
        logic [DEF_REG_DATA_WIDTH-1:0]   data;
    } wb_req_t;

    // Successor of idx in a ring of n entries.
    function automatic int wrap_next(input int idx, input int n);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/phy_regfile_wb_arbiter_rr_multi_picker.sv
// Combinational round-robin picker granting up to WB_WIDTH requests per cycle,
// scanning from ptr upward with wrap; k-th grant in scan order maps to port k.
module rr_multi_picker #(
    parameter int REQ_NUM  = 4,
    parameter int WB_WIDTH = 2,
    localparam int IDX_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]               req,
    input  logic [IDX_W-1:0]                 ptr,
    output logic [REQ_NUM-1:0]               grant,
    output logic [WB_WIDTH-1:0][REQ_NUM-1:0] port_sel,
    output logic [IDX_W-1:0]                 last_idx,
    output logic                             any_grant
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;
    int               cnt_s;

    // Walk the ring once, handing out ports in scan order until they run out.
    always_comb begin
        grant    = '0;
        port_sel = '0;
        last_idx = '0;
        sum_s    = '0;
        idx_s    = '0;
        cnt_s    = 32'sd0;
        for (int j = 0; j < REQ_NUM; j++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(j);
            if (sum_s >= (IDX_W+1)'(REQ_NUM)) begin
                sum_s = sum_s - (IDX_W+1)'(REQ_NUM);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDX_W-1:0];
            if (req[idx_s] && (cnt_s < WB_WIDTH)) begin
                grant[idx_s] = 1'b1;
                for (int k = 0; k < WB_WIDTH; k++) begin
                    if (cnt_s == k) begin
                        port_sel[k][idx_s] = 1'b1;
                    end else begin
                        port_sel[k][idx_s] = port_sel[k][idx_s];
                    end
                end
                last_idx = idx_s;
                cnt_s    = cnt_s + 32'sd1;
            end else begin
                cnt_s = cnt_s;
            end
        end
        any_grant = |grant;
    end

endmodule

// File: rtl/phy_regfile_wb_arbiter.sv
// Shares the register-file write-back ports among execution-unit results with
// a round-robin multi-grant arbiter; granted results are registered onto the ports.
module phy_regfile_wb_arbiter
    import phy_regfile_wb_arbiter_pkg::*;
#(
    parameter int REQ_NUM          = DEF_REQ_NUM,
    parameter int WB_WIDTH         = DEF_WB_WIDTH,
    parameter int PHY_REG_ID_WIDTH = DEF_PHY_REG_ID_WIDTH,
    parameter int REG_DATA_WIDTH   = DEF_REG_DATA_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [REQ_NUM-1:0]                       req_valid,
    input  logic [REQ_NUM-1:0][PHY_REG_ID_WIDTH-1:0] req_id,
    input  logic [REQ_NUM-1:0][REG_DATA_WIDTH-1:0]   req_data,
    output logic [REQ_NUM-1:0]                       req_ready,
    input  logic                                     flush,
    output logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] wb_phyf_id,
    output logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]   wb_phyf_data,
    output logic [WB_WIDTH-1:0]                       wb_phyf_we,
    output logic                                      arb_busy
);

    localparam int IDX_W = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0]                        grant_s;
    logic [WB_WIDTH-1:0][REQ_NUM-1:0]          port_sel_s;
    logic [IDX_W-1:0]                          last_idx_s;
    logic                                      any_grant_s;
    logic [REQ_NUM-1:0]                        ready_s;
    logic [WB_WIDTH-1:0]                       port_we_s;
    logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] port_id_s;
    logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]   port_data_s;
    logic [IDX_W-1:0]                          ptr_nxt_s;
    logic                                      busy_s;

    logic [IDX_W-1:0]                          rr_ptr_r;
    logic [WB_WIDTH-1:0]                       we_r;
    logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] id_r;
    logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]   data_r;
    logic                                      busy_r;

    rr_multi_picker #(
        .REQ_NUM  (REQ_NUM),
        .WB_WIDTH (WB_WIDTH)
    ) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .port_sel  (port_sel_s),
        .last_idx  (last_idx_s),
        .any_grant (any_grant_s)
    );

    // Grants are withheld during reset and flush so no transfer can be lost.
    always_comb begin
        ready_s = '0;
        if (rst || flush) begin
            ready_s = '0;
        end else begin
            ready_s = grant_s & req_valid;
        end
    end

    // AND-OR mux of the selected requester onto each write port.
    always_comb begin
        port_we_s   = '0;
        port_id_s   = '0;
        port_data_s = '0;
        for (int k = 0; k < WB_WIDTH; k++) begin
            port_we_s[k] = |(port_sel_s[k] & ready_s);
            for (int i = 0; i < REQ_NUM; i++) begin
                port_id_s[k]   = port_id_s[k]   | (req_id[i]   & {PHY_REG_ID_WIDTH{port_sel_s[k][i]}});
                port_data_s[k] = port_data_s[k] | (req_data[i] & {REG_DATA_WIDTH{port_sel_s[k][i]}});
            end
        end
    end

    // Pointer advances past the last winner; idle or flushed cycles leave it.
    always_comb begin
        ptr_nxt_s = rr_ptr_r;
        if (any_grant_s && (|ready_s)) begin
            ptr_nxt_s = IDX_W'(wrap_next(int'(last_idx_s), REQ_NUM));
        end else begin
            ptr_nxt_s = rr_ptr_r;
        end
        busy_s = (|(req_valid & ~ready_s)) && !flush;
    end

    // Pointer and write-port registers; idle ports keep their last id/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
            we_r     <= '0;
            id_r     <= '0;
            data_r   <= '0;
            busy_r   <= 1'b0;
        end else begin
            rr_ptr_r <= ptr_nxt_s;
            we_r     <= port_we_s;
            busy_r   <= busy_s;
            for (int k = 0; k < WB_WIDTH; k++) begin
                if (port_we_s[k]) begin
                    id_r[k]   <= port_id_s[k];
                    data_r[k] <= port_data_s[k];
                end else begin
                    id_r[k]   <= id_r[k];
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    assign req_ready    = ready_s;
    assign wb_phyf_we   = we_r;
    assign wb_phyf_id   = id_r;
    assign wb_phyf_data = data_r;
    assign arb_busy     = busy_r;

endmodule

// File: tb/tb_phy_regfile_wb_arbiter.sv
// Scoreboard bench: the driver checks grants and queues the expected write-port
// contents; a monitor compares them whenever the DUT asserts a write enable.
module tb_phy_regfile_wb_arbiter;
    import phy_regfile_wb_arbiter_pkg::*;

    localparam int RN = 4;
    localparam int WW = 2;
    localparam int IW = 7;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [RN-1:0]           req_valid;
    logic [RN-1:0][IW-1:0]   req_id;
    logic [RN-1:0][DW-1:0]   req_data;
    logic [RN-1:0]           req_ready;
    logic                    flush;
    logic [WW-1:0][IW-1:0]   wb_phyf_id;
    logic [WW-1:0][DW-1:0]   wb_phyf_data;
    logic [WW-1:0]           wb_phyf_we;
    logic                    arb_busy;

    typedef struct {
        logic [WW-1:0]         we;
        logic [WW-1:0][IW-1:0] id;
        logic [WW-1:0][DW-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [DW-1:0] rf   [0:(1<<IW)-1];
    logic          rf_v [0:(1<<IW)-1];

    always #5 clk = ~clk;

    phy_regfile_wb_arbiter #(
        .REQ_NUM(RN), .WB_WIDTH(WW), .PHY_REG_ID_WIDTH(IW), .REG_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id),
        .req_data(req_data), .req_ready(req_ready), .flush(flush),
        .wb_phyf_id(wb_phyf_id), .wb_phyf_data(wb_phyf_data),
        .wb_phyf_we(wb_phyf_we), .arb_busy(arb_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle: drive inputs after the edge, check grants and the registered
    // busy flag, and queue the writes these grants must produce next cycle.
    task automatic step(input logic [RN-1:0] v, input logic fl, input logic r,
                        input logic [RN-1:0] exp_ready, input logic exp_busy,
                        input logic [WW-1:0] exp_we, input int p0, input int p1);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        flush     = fl;
        rst       = r;
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("arb_busy", 64'(arb_busy), 64'(exp_busy));
        if (exp_we != 2'b00) begin
            e.we      = exp_we;
            e.id[0]   = req_id[p0];
            e.data[0] = req_data[p0];
            e.id[1]   = req_id[p1];
            e.data[1] = req_data[p1];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every asserted write enable must match the oldest expectation.
    always @(negedge clk) begin
        if (|wb_phyf_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got we=%b id0=%0d id1=%0d expected no write",
                         wb_phyf_we, wb_phyf_id[0], wb_phyf_id[1]);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_we", 64'(wb_phyf_we), 64'(mon_e.we));
                for (int k = 0; k < WW; k++) begin
                    if (mon_e.we[k]) begin
                        check($sformatf("wb_id%0d", k), 64'(wb_phyf_id[k]), 64'(mon_e.id[k]));
                        check($sformatf("wb_data%0d", k), 64'(wb_phyf_data[k]), 64'(mon_e.data[k]));
                    end
                end
            end
            for (int k = 0; k < WW; k++) begin
                if (wb_phyf_we[k]) begin
                    rf[wb_phyf_id[k]]   = wb_phyf_data[k];
                    rf_v[wb_phyf_id[k]] = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < RN; i++) begin
            req_id[i]   = IW'(i + 1);
            req_data[i] = 32'h1acdef89 + 32'(i);
        end
        for (int i = 0; i < (1 << IW); i++) begin
            rf[i]   = 32'h0;
            rf_v[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(req_ready), 64'h0);

        // Reset release, idle
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);
        check("reset_we", 64'(wb_phyf_we), 64'h0);
        check("reset_id", 64'(wb_phyf_id), 64'h0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);

        // All valid for three cycles: pairs alternate, busy while pending
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 1'b0, 2'b11, 0, 1);
        step(4'b1111, 1'b0, 1'b0, 4'b1100, 1'b1, 2'b11, 2, 3);
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 1'b1, 2'b11, 0, 1);

        // Pointer at 2, req0 and req3: req3 wraps ahead of req0
        step(4'b1001, 1'b0, 1'b0, 4'b1001, 1'b1, 2'b11, 3, 0);

        // Pointer at 1, only req1 with id 10
        req_id[1]   = 7'd10;
        req_data[1] = 32'h55;
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 2'b01, 1, 0);

        // Flush: no grants, no busy, pointer held at 2
        step(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);
        step(4'b1111, 1'b0, 1'b0, 4'b1100, 1'b0, 2'b11, 2, 3);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 0, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);

        // Regfile path: write ids 5 and 6
        req_id[0]   = 7'd5;
        req_data[0] = 32'hA5A50005;
        req_id[1]   = 7'd6;
        req_data[1] = 32'hA5A50006;
        step(4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0, 2'b11, 0, 1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);

        // Reset in the same cycle as a would-be grant: nothing written
        req_id[0]   = 7'd7;
        req_data[0] = 32'hDEAD0007;
        req_id[1]   = 7'd8;
        req_data[1] = 32'hDEAD0008;
        step(4'b0011, 1'b0, 1'b1, 4'b0000, 1'b0, 2'b00, 0, 0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);
        check("rst_we", 64'(wb_phyf_we), 64'h0);
        check("rst_id", 64'(wb_phyf_id), 64'h0);
        check("rst_data", 64'(wb_phyf_data), 64'h0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 0, 0);
        @(negedge clk);

        check("rf5_valid", 64'(rf_v[5]), 64'h1);
        check("rf5_data", 64'(rf[5]), 64'hA5A50005);
        check("rf6_valid", 64'(rf_v[6]), 64'h1);
        check("rf6_data", 64'(rf[6]), 64'hA5A50006);
        check("rf7_not_written", 64'(rf_v[7]), 64'h0);
        check("rf8_not_written", 64'(rf_v[8]), 64'h0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_regfile_wb_arbiter.md
Name: phy_regfile_wb_arbiter

Overview:
- Shares the physical register file's `WB_WIDTH` write-back ports between `REQ_NUM` execution-unit result sources.
- Each cycle it grants up to `WB_WIDTH` valid requesters in round-robin order, using a valid/ready handshake.
- Granted results are registered onto `wb_phyf_id`, `wb_phyf_data` and `wb_phyf_we`, which feed the physical register file directly.
- Ungranted requesters hold their results and retry the next cycle.

Parameters:
- REQ_NUM, 4, number of result requesters (≥ `WB_WIDTH`).
- WB_WIDTH, `` `WB_WIDTH `` (2), number of regfile write ports driven.
- PHY_REG_ID_WIDTH, `` `PHY_REG_ID_WIDTH ``, physical register id width.
- REG_DATA_WIDTH, `` `REG_DATA_WIDTH ``, register data width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [REQ_NUM]  requester i holds a result.
- req_id  in  [REQ_NUM][PHY_REG_ID_WIDTH]  destination physical register of requester i.
- req_data  in  [REQ_NUM][REG_DATA_WIDTH]  result value of requester i.
- req_ready  out  [REQ_NUM]  combinational grant; a transfer happens when req_valid[i] && req_ready[i].
- flush  in  1  pipeline flush; no grants this cycle.
- wb_phyf_id  out  [WB_WIDTH][PHY_REG_ID_WIDTH]  registered write id per port.
- wb_phyf_data  out  [WB_WIDTH][REG_DATA_WIDTH]  registered write data per port.
- wb_phyf_we  out  [WB_WIDTH]  registered write enable per port.
- arb_busy  out  1  registered; 1 when any requester was valid but not granted in the previous cycle.

Behaviour:
- Reset values: wb_phyf_we=0, wb_phyf_id=0, wb_phyf_data=0, arb_busy=0, rr_ptr=0. req_ready is 0 while rst=1.
- State: rr_ptr (clog2(REQ_NUM) bits), plus the output registers.
- Grant selection is combinational:
  - Scan requesters in order rr_ptr, rr_ptr+1, … with wrap modulo REQ_NUM.
  - The first WB_WIDTH requesters with req_valid=1 get req_ready=1; all others get 0.
  - req_ready never depends on a requester's own req_valid in a way that forms a loop. ready = valid && selected.
- Port mapping: the k-th granted requester in scan order drives write port k. Ports beyond the grant count have we=0; their id/data hold the previous values.
- Latency: 1 cycle. Granted in cycle N ⇒ wb_phyf_we[k]=1 with that id/data during cycle N+1.
- Full rate: every port can be written every cycle. No bubbles between back-to-back grants.
- rr_ptr update:
  - If ≥1 grant: rr_ptr ← (index of the last granted requester + 1) mod REQ_NUM.
  - If no grant: rr_ptr unchanged.
- Fairness: with all requesters continuously valid, every requester is granted at least once every ceil(REQ_NUM/WB_WIDTH) cycles.
- flush=1:
  - All req_ready=0 that cycle.
  - Next cycle wb_phyf_we=0 and arb_busy=0.
  - rr_ptr unchanged.
  - Writes already registered (issued in the flush cycle) still complete.
- rst=1 mid-operation: outputs go to their reset values on the next edge. A grant presented in the same cycle is discarded, and requesters see ready=0.
- arb_busy ← |(req_valid & ~req_ready) && !flush.
- Id collisions:
  - Rename guarantees distinct req_id among simultaneously valid requesters; the block does not check this.
  - Id 0 is a legal id and is not filtered.
- No other state. No FSM beyond the pointer, because arbitration is stateless apart from rr_ptr.

Decomposition:
- Shared package/config:
  - `REQ_NUM` default as `` `WB_REQ_NUM `` in config.svh.
  - A typedef wb_req_t {id, data}, reusable by execution units.
- One natural sub-module: rr_multi_picker.
  - Inputs: a REQ_NUM-bit request vector and rr_ptr.
  - Outputs: grant vector, per-port one-hot select, and last-grant index.
  - Combinational and independently testable.
- The top level holds rr_ptr, the output registers and the data muxing.

Test Plan:
1. Reset, then idle, REQ_NUM=4, WB_WIDTH=2 → wb_phyf_we=2'b00, req_ready=0, arb_busy=0.
2. All 4 valid, ids 1..4, data 'h1acdef89+i, held for 3 cycles:
   - Cycle 0 ready=4'b0011; cycle 1 ports (1,2) written, ready=4'b1100; cycle 2 ports (3,4) written, ready=4'b0011.
   - arb_busy=1 on the cycle after each grant while requesters are still pending.
3. rr_ptr=2, only req0 and req3 valid:
   - Grants req3→port0, req0→port1.
   - rr_ptr→1.
4. Only req1 valid, id 10, data 'h55 → next cycle wb_phyf_we=2'b01, port0 id 10/data 'h55, rr_ptr=2.
5. All valid with flush=1 for one cycle:
   - req_ready=0; next cycle we=0 and arb_busy=0.
   - rr_ptr unchanged.
   - The following cycle resumes from the same pointer.
6. With phy_regfile attached:
   - Write ids 5 and 6 through the arbiter.
   - Next cycle, phy_regfile readreg data_valid=1 with the matching data.
   - A reset asserted the same cycle as a grant → no write reaches phy_regfile.
